run_ctrl: RTL and testbench

- Parametrised run controller that sequences the processor core through a req/done four-phase handshake.
- Selects one of NUM_PROGS program start addresses, holds the core in reset while loading the PC, then enables execution until the core reports program completion.
- Includes a cycle counter, a programmable watchdog timeout and an error code.
- Sits between the testbench/host handshake and the core's PC/instruction-ROM reset and enable inputs.

---
 rtl/run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_run_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// ============================================================================
//  Module   : run_ctrl
//  Purpose  : Four-phase req/done run controller that loads a start PC into
//             the core, releases it, and watches for completion or timeout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module run_ctrl #(
  parameter int PC_W      = 12,
  parameter int NUM_PROGS = 3,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req,
  input  logic [SEL_W-1:0]          i_prog_sel,
  input  logic [NUM_PROGS*PC_W-1:0] i_start_addrs,
  input  logic [CNT_W-1:0]          i_timeout_cycles,
  input  logic                      i_core_done,
  output logic                      o_core_rst,
  output logic                      o_core_en,
  output logic [PC_W-1:0]           o_core_start_pc,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [1:0]                o_err,
  output logic [SEL_W-1:0]          o_active_prog,
  output logic [CNT_W-1:0]          o_cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [1:0] c_ERR_OK      = 2'b00;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] c_ERR_BADSEL  = 2'b10;
  localparam logic [1:0] c_ERR_ABORT   = 2'b11;

  state_t            r_state;
  logic              r_core_rst;
  logic              r_core_en;
  logic [PC_W-1:0]   r_core_start_pc;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_err;
  logic [SEL_W-1:0]  r_active_prog;
  logic [CNT_W-1:0]  r_cycle_count;

  logic              w_sel_ok;
  logic [PC_W-1:0]   w_sel_pc;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_timeout_hit;

  assign w_sel_ok = (32'(i_prog_sel) < NUM_PROGS);

  // Explicit mux avoids indexing past the packed vector for illegal selects.
  always_comb begin
    w_sel_pc = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (32'(i_prog_sel) == i) begin
        w_sel_pc = i_start_addrs[i*PC_W +: PC_W];
      end
    end
  end

  assign w_cnt_inc     = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;
  assign w_timeout_hit = (i_timeout_cycles != '0) && (w_cnt_inc == i_timeout_cycles);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_core_rst      <= 1'b1;
      r_core_en       <= 1'b0;
      r_core_start_pc <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= c_ERR_OK;
      r_active_prog   <= '0;
      r_cycle_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_core_rst <= 1'b1;
          r_core_en  <= 1'b0;
          if (i_req) begin
            r_cycle_count <= '0;
            if (w_sel_ok) begin
              r_state         <= S_LOAD;
              r_active_prog   <= i_prog_sel;
              r_core_start_pc <= w_sel_pc;
              r_err           <= c_ERR_OK;
              r_busy          <= 1'b1;
            end else begin
              // Core stays in reset; only the handshake completes.
              r_state <= S_FINISH;
              r_err   <= c_ERR_BADSEL;
              r_done  <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (!i_req) begin
            r_state <= S_IDLE;
            r_err   <= c_ERR_ABORT;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= S_RUN;
            r_core_rst <= 1'b0;
            r_core_en  <= 1'b1;
          end
        end

        S_RUN: begin
          r_cycle_count <= w_cnt_inc;
          if (!i_req) begin
            r_state    <= S_IDLE;
            r_err      <= c_ERR_ABORT;
            r_busy     <= 1'b0;
            r_core_en  <= 1'b0;
            r_core_rst <= 1'b1;
          end else if (i_core_done || w_timeout_hit) begin
            r_state   <= S_FINISH;
            r_err     <= i_core_done ? c_ERR_OK : c_ERR_TIMEOUT;
            r_busy    <= 1'b0;
            r_core_en <= 1'b0;
            r_done    <= 1'b1;
          end
        end

        S_FINISH: begin
          r_core_en <= 1'b0;
          if (!i_req) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_core_rst <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_core_rst      = r_core_rst;
  assign o_core_en       = r_core_en;
  assign o_core_start_pc = r_core_start_pc;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_active_prog   = r_active_prog;
  assign o_cycle_count   = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_run_ctrl.sv
// ============================================================================
//  Module   : tb_run_ctrl
//  Purpose  : Directed self-checking bench for run_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_run_ctrl;

  localparam int PC_W      = 12;
  localparam int NUM_PROGS = 3;
  localparam int SEL_W     = 2;
  localparam int CNT_W     = 16;

  logic                      clk;
  logic                      reset;
  logic                      i_req;
  logic [SEL_W-1:0]          i_prog_sel;
  logic [NUM_PROGS*PC_W-1:0] i_start_addrs;
  logic [CNT_W-1:0]          i_timeout_cycles;
  logic                      i_core_done;
  logic                      o_core_rst;
  logic                      o_core_en;
  logic [PC_W-1:0]           o_core_start_pc;
  logic                      o_busy;
  logic                      o_done;
  logic [1:0]                o_err;
  logic [SEL_W-1:0]          o_active_prog;
  logic [CNT_W-1:0]          o_cycle_count;

  int r_checks;
  int r_errors;
  int r_en_cnt;
  int r_done_seen;

  run_ctrl #(
    .PC_W      (PC_W),
    .NUM_PROGS (NUM_PROGS),
    .SEL_W     (SEL_W),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .i_req            (i_req),
    .i_prog_sel       (i_prog_sel),
    .i_start_addrs    (i_start_addrs),
    .i_timeout_cycles (i_timeout_cycles),
    .i_core_done      (i_core_done),
    .o_core_rst       (o_core_rst),
    .o_core_en        (o_core_en),
    .o_core_start_pc  (o_core_start_pc),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err),
    .o_active_prog    (o_active_prog),
    .o_cycle_count    (o_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then tally core_en / done for the cycle just entered.
  task automatic step();
    @(posedge clk);
    #1;
    if (o_core_en) r_en_cnt++;
    if (o_done) r_done_seen++;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start(input logic [SEL_W-1:0] sel);
    i_prog_sel  = sel;
    i_req       = 1'b1;
    r_en_cnt    = 0;
    r_done_seen = 0;
    step();
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!o_done && n < max_cycles) begin
      step();
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(o_done), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_rst"}, 32'(o_core_rst), 32'd1);
    chk({tag, "_core_en"},  32'(o_core_en),  32'd0);
    chk({tag, "_start_pc"}, 32'(o_core_start_pc), 32'd0);
    chk({tag, "_busy"},     32'(o_busy), 32'd0);
    chk({tag, "_done"},     32'(o_done), 32'd0);
    chk({tag, "_err"},      32'(o_err), 32'd0);
    chk({tag, "_active"},   32'(o_active_prog), 32'd0);
    chk({tag, "_count"},    32'(o_cycle_count), 32'd0);
  endtask

  initial begin
    r_checks         = 0;
    r_errors         = 0;
    r_en_cnt         = 0;
    r_done_seen      = 0;
    reset            = 1'b1;
    i_req            = 1'b0;
    i_prog_sel       = '0;
    i_start_addrs    = {12'h200, 12'h100, 12'h000};
    i_timeout_cycles = '0;
    i_core_done      = 1'b0;
    step_n(2);
    check_reset_vals("rst");
    reset = 1'b0;
    step();

    // Nominal: program 1, done in 5th RUN cycle
    start(2'd1);
    chk("nom_load_pc",     32'(o_core_start_pc), 32'h100);
    chk("nom_load_rst",    32'(o_core_rst), 32'd1);
    chk("nom_load_busy",   32'(o_busy), 32'd1);
    chk("nom_active",      32'(o_active_prog), 32'd1);
    step();
    chk("nom_run_en",      32'(o_core_en), 32'd1);
    chk("nom_run_rst",     32'(o_core_rst), 32'd0);
    step_n(4);
    i_core_done = 1'b1;
    step();
    i_core_done = 1'b0;
    chk("nom_done",        32'(o_done), 32'd1);
    chk("nom_err",         32'(o_err), 32'd0);
    chk("nom_count",       32'(o_cycle_count), 32'd5);
    chk("nom_en_cycles",   32'(r_en_cnt), 32'd5);
    chk("nom_fin_rst",     32'(o_core_rst), 32'd0);
    chk("nom_fin_busy",    32'(o_busy), 32'd0);
    i_req = 1'b0;
    step();
    chk("nom_ack_low",     32'(o_done), 32'd0);
    chk("nom_idle_rst",    32'(o_core_rst), 32'd1);
    chk("nom_idle_count",  32'(o_cycle_count), 32'd5);

    // Timeout after 8 RUN cycles
    i_timeout_cycles = 16'd8;
    start(2'd0);
    chk("to_load_pc",      32'(o_core_start_pc), 32'h000);
    wait_done("to", 50);
    chk("to_err",          32'(o_err), 32'd1);
    chk("to_count",        32'(o_cycle_count), 32'd8);
    chk("to_en_cycles",    32'(r_en_cnt), 32'd8);
    i_req = 1'b0;
    step();

    // Watchdog disabled, done at cycle 300
    i_timeout_cycles = 16'd0;
    start(2'd0);
    step();
    step_n(299);
    chk("long_no_done",    32'(r_done_seen), 32'd0);
    i_core_done = 1'b1;
    step();
    i_core_done = 1'b0;
    chk("long_done",       32'(o_done), 32'd1);
    chk("long_err",        32'(o_err), 32'd0);
    chk("long_count",      32'(o_cycle_count), 32'd300);
    chk("long_en_cycles",  32'(r_en_cnt), 32'd300);
    i_req = 1'b0;
    step();

    // core_done and timeout on the same edge
    i_timeout_cycles = 16'd4;
    start(2'd0);
    step();
    step_n(3);
    i_core_done = 1'b1;
    step();
    i_core_done = 1'b0;
    chk("sim_done",        32'(o_done), 32'd1);
    chk("sim_err",         32'(o_err), 32'd0);
    chk("sim_count",       32'(o_cycle_count), 32'd4);
    i_req = 1'b0;
    step();
    i_timeout_cycles = 16'd0;

    // Illegal program select
    start(2'd3);
    chk("bad_done",        32'(o_done), 32'd1);
    chk("bad_err",         32'(o_err), 32'd2);
    chk("bad_busy",        32'(o_busy), 32'd0);
    step_n(3);
    chk("bad_core_rst",    32'(o_core_rst), 32'd1);
    chk("bad_en_never",    32'(r_en_cnt), 32'd0);
    i_req = 1'b0;
    step();
    chk("bad_ack_low",     32'(o_done), 32'd0);

    // Abort in RUN cycle 3
    start(2'd2);
    step();
    step_n(2);
    i_req = 1'b0;
    step();
    chk("abort_err",       32'(o_err), 32'd3);
    chk("abort_count",     32'(o_cycle_count), 32'd3);
    chk("abort_busy",      32'(o_busy), 32'd0);
    chk("abort_en",        32'(o_core_en), 32'd0);
    chk("abort_rst",       32'(o_core_rst), 32'd1);
    step_n(2);
    chk("abort_no_done",   32'(r_done_seen), 32'd0);

    // Reset pulsed mid-run
    start(2'd1);
    step_n(3);
    reset = 1'b1;
    step();
    check_reset_vals("midrst");
    reset = 1'b0;
    i_req = 1'b0;
    step();

    // Back-to-back: req held high through FINISH must not retrigger
    start(2'd1);
    step();
    step();
    i_core_done = 1'b1;
    step();
    i_core_done = 1'b0;
    chk("b2b_count1",      32'(o_cycle_count), 32'd2);
    step_n(5);
    chk("b2b_hold_done",   32'(o_done), 32'd1);
    chk("b2b_hold_busy",   32'(o_busy), 32'd0);
    chk("b2b_no_rerun",    32'(r_en_cnt), 32'd2);
    i_req = 1'b0;
    step();
    start(2'd2);
    chk("b2b_pc",          32'(o_core_start_pc), 32'h200);
    chk("b2b_count_clr",   32'(o_cycle_count), 32'd0);
    chk("b2b_active",      32'(o_active_prog), 32'd2);
    step();
    i_core_done = 1'b1;
    step();
    i_core_done = 1'b0;
    chk("b2b_count2",      32'(o_cycle_count), 32'd1);
    chk("b2b_err2",        32'(o_err), 32'd0);
    i_req = 1'b0;
    step();
    chk("b2b_ack_low",     32'(o_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
    $finish;
  end

endmodule

`default_nettype wire
